// File: rtl/sampler_tag_match_table.sv
// sampler_tag_match_table: associative tag table with a two-stage chunked compare, victim replacement and optional retire-on-hit.
module sampler_tag_match_table #(
  parameter int TAG_W = 20,
  parameter int DEPTH = 8,
  parameter int INVAL_ON_HIT = 1
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     insert_i,
  input  logic [TAG_W-1:0]         tag_i,
  input  logic                     lookup_i,
  input  logic [TAG_W-1:0]         key_i,
  output logic                     valid_o,
  output logic                     hit_o,
  output logic [$clog2(DEPTH)-1:0] index_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);
  localparam int IW = $clog2(DEPTH);
  localparam int NC = TAG_W / 4;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [TAG_W-1:0] tag_d [DEPTH];
  logic [DEPTH-1:0][NC-1:0] cm_q, cm_d;
  logic [DEPTH-1:0] valid_q, valid_d, live_q, live_d, wr_vec, inv_vec, match;
  logic [IW-1:0] victim_q, victim_d, free_idx, hit_idx, out_idx_q, out_idx_d;
  logic [IW:0] count_q, count_d;
  logic s1_q, s1_d, out_vld_q, out_vld_d, out_hit_q, out_hit_d;
  logic full, ins, hit;
  always_comb begin
    full = &valid_q;
    ins = insert_i & ~flush_i;
    free_idx = '0;
    for (int e = DEPTH - 1; e >= 0; e--) if (!valid_q[e]) free_idx = IW'(e);
    wr_vec = ins ? DEPTH'(1) << (full ? victim_q : free_idx) : '0;
    // an insert landing on this edge must not let the old tag report a hit
    for (int e = 0; e < DEPTH; e++) match[e] = s1_q & live_q[e] & ~wr_vec[e] & (&cm_q[e]);
    hit_idx = '0;
    for (int e = DEPTH - 1; e >= 0; e--) if (match[e]) hit_idx = IW'(e);
    hit = |match;
    inv_vec = (INVAL_ON_HIT != 0 && hit) ? DEPTH'(1) << hit_idx : '0;
    for (int e = 0; e < DEPTH; e++) tag_d[e] = wr_vec[e] ? tag_i : tag_q[e];
    for (int e = 0; e < DEPTH; e++)
      for (int c = 0; c < NC; c++) cm_d[e][c] = tag_q[e][4*c +: 4] == key_i[4*c +: 4];
    live_d = valid_q & ~wr_vec & ~inv_vec;
    s1_d = lookup_i & ~flush_i;
    valid_d = flush_i ? '0 : (valid_q & ~inv_vec) | wr_vec;
    victim_d = flush_i ? '0 : victim_q + IW'(ins & full);
    count_d = flush_i ? '0 : count_q + (IW+1)'(ins & ~full) - (IW+1)'(|(inv_vec & ~wr_vec));
    out_vld_d = s1_q & ~flush_i;
    out_hit_d = hit & ~flush_i;
    out_idx_d = flush_i ? '0 : hit_idx;
  end
  always_ff @(posedge clock_i) begin
    tag_q <= tag_d;
    cm_q <= cm_d;
  end
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= '0;
      live_q <= '0;
      victim_q <= '0;
      count_q <= '0;
      s1_q <= 1'b0;
      out_vld_q <= 1'b0;
      out_hit_q <= 1'b0;
      out_idx_q <= '0;
    end else begin
      valid_q <= valid_d;
      live_q <= live_d;
      victim_q <= victim_d;
      count_q <= count_d;
      s1_q <= s1_d;
      out_vld_q <= out_vld_d;
      out_hit_q <= out_hit_d;
      out_idx_q <= out_idx_d;
    end
  end
  assign valid_o = out_vld_q;
  assign hit_o = out_hit_q;
  assign index_o = out_idx_q;
  assign count_o = count_q;
  assign full_o = count_q[IW];
endmodule

// File: tb/tb_sampler_tag_match_table.sv
// tb_sampler_tag_match_table: directed stimulus with a queued scoreboard checked by per-instance output monitors.
module tb_sampler_tag_match_table;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic ins0 = 1'b0, lk0 = 1'b0, ins1 = 1'b0, lk1 = 1'b0;
  logic [19:0] tag0 = '0, key0 = '0, tag1 = '0, key1 = '0;
  logic v0, h0, f0, v1, h1, f1;
  logic [2:0] i0, i1;
  logic [3:0] c0, c1, e0, e1;
  logic [3:0] q0[$];
  logic [3:0] q1[$];
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  sampler_tag_match_table #(.TAG_W(20), .DEPTH(8), .INVAL_ON_HIT(1)) u0 (
    .clock_i(clk), .reset_i(rst), .flush_i(flush), .insert_i(ins0), .tag_i(tag0),
    .lookup_i(lk0), .key_i(key0), .valid_o(v0), .hit_o(h0), .index_o(i0),
    .count_o(c0), .full_o(f0));

  sampler_tag_match_table #(.TAG_W(20), .DEPTH(8), .INVAL_ON_HIT(0)) u1 (
    .clock_i(clk), .reset_i(rst), .flush_i(flush), .insert_i(ins1), .tag_i(tag1),
    .lookup_i(lk1), .key_i(key1), .valid_o(v1), .hit_o(h1), .index_o(i1),
    .count_o(c1), .full_o(f1));

  task automatic chk(string n, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op0(logic i, logic [19:0] t, logic l, logic [19:0] k);
    ins0 = i; tag0 = t; lk0 = l; key0 = k;
    tick();
    ins0 = 1'b0; lk0 = 1'b0;
  endtask

  task automatic look0(logic [19:0] k, logic h, logic [2:0] idx);
    q0.push_back({h, idx});
    op0(1'b0, '0, 1'b1, k);
  endtask

  task automatic op1(logic i, logic [19:0] t, logic l, logic [19:0] k);
    ins1 = i; tag1 = t; lk1 = l; key1 = k;
    tick();
    ins1 = 1'b0; lk1 = 1'b0;
  endtask

  always @(negedge clk) if (!rst && v0) begin
    if (q0.size() == 0) chk("u0 unexpected valid_o", 1, 0);
    else begin
      e0 = q0.pop_front();
      chk("u0 hit_o", h0, e0[3]);
      chk("u0 index_o", i0, e0[2:0]);
    end
  end

  always @(negedge clk) if (!rst && v1) begin
    if (q1.size() == 0) chk("u1 unexpected valid_o", 1, 0);
    else begin
      e1 = q1.pop_front();
      chk("u1 hit_o", h1, e1[3]);
      chk("u1 index_o", i1, e1[2:0]);
    end
  end

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("reset valid_o", v0, 0);
    chk("reset hit_o", h0, 0);
    chk("reset index_o", i0, 0);
    chk("reset count_o", c0, 0);
    chk("reset full_o", f0, 0);
    // entries kept on hit: both back-to-back lookups hit index 1
    op1(1'b1, 20'h3C3C3, 1'b0, '0);
    op1(1'b1, 20'h12345, 1'b0, '0);
    q1.push_back({1'b1, 3'd1});
    op1(1'b0, '0, 1'b1, 20'h12345);
    q1.push_back({1'b1, 3'd1});
    op1(1'b0, '0, 1'b1, 20'h12345);
    repeat (2) tick();
    chk("u1 count kept", c1, 2);
    // insert then hit-and-retire
    op0(1'b1, 20'hABCDE, 1'b0, '0);
    chk("count after insert", c0, 1);
    look0(20'hABCDE, 1'b1, 3'd0);
    tick();
    chk("count after retire", c0, 0);
    look0(20'hABCDE, 1'b0, 3'd0);
    repeat (2) tick();
    // fill, then victim replacement
    for (int i = 0; i < 8; i++) op0(1'b1, 20'(i), 1'b0, '0);
    chk("count full", c0, 8);
    chk("full_o set", f0, 1);
    op0(1'b1, 20'h100, 1'b0, '0);
    op0(1'b1, 20'h200, 1'b0, '0);
    chk("count after overwrites", c0, 8);
    look0(20'h1, 1'b0, 3'd0);
    look0(20'h200, 1'b1, 3'd1);
    look0(20'h0, 1'b0, 3'd0);
    look0(20'h100, 1'b1, 3'd0);
    repeat (2) tick();
    chk("count after two retires", c0, 6);
    chk("full_o cleared", f0, 0);
    // flush drops a same-cycle insert
    flush = 1'b1; ins0 = 1'b1; tag0 = 20'h55;
    tick();
    flush = 1'b0; ins0 = 1'b0;
    chk("count after flush", c0, 0);
    op0(1'b1, 20'hABCDE, 1'b0, '0);
    look0(20'h2BCDE, 1'b0, 3'd0);
    look0(20'hABCDF, 1'b0, 3'd0);
    look0(20'hABCCE, 1'b0, 3'd0);
    look0(20'hABCDE, 1'b1, 3'd0);
    look0(20'hABCDE, 1'b0, 3'd0);
    repeat (2) tick();
    chk("count after retire 2", c0, 0);
    // overwrite of entry 3 while its lookup is in flight
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 8; i++) op0(1'b1, 20'h10 + 20'(i), 1'b0, '0);
    for (int i = 0; i < 3; i++) op0(1'b1, 20'h20 + 20'(i), 1'b0, '0);
    look0(20'h13, 1'b0, 3'd0);
    op0(1'b1, 20'h99, 1'b0, '0);
    look0(20'h99, 1'b1, 3'd3);
    repeat (2) tick();
    chk("count after overwrite hit", c0, 7);
    // flush one cycle after a lookup kills its result
    op0(1'b0, '0, 1'b1, 20'h20);
    flush = 1'b1; ins0 = 1'b1; tag0 = 20'h77;
    tick();
    flush = 1'b0; ins0 = 1'b0;
    repeat (2) tick();
    chk("count after flush 2", c0, 0);
    look0(20'h77, 1'b0, 3'd0);
    repeat (3) tick();
    chk("scoreboard drained", q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
